mode_scheduler: RTL and testbench
=================================

MODE_SCHEDULER -- requirements
Module: mode_scheduler

Interface
REQ-001 Parameter TIEMPO_SEL, default 10: tick count without a button press before SELECT returns to IDLE.
REQ-002 Parameter N_NEEDS, default 4: number of need counters sequenced; fixed at 4 in this revision.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 B_reset  input  1  asynchronous, active-low reset.
REQ-005 tick  input  1  one-cycle timebase enable, nominally 1 Hz.
REQ-006 btn_mode  input  1  raw mode button, asynchronous to clk.
REQ-007 btn_action  input  1  raw action button, asynchronous to clk.
REQ-008 nivel  input  8  four 2-bit need levels: [1:0] hunger, [3:2] fun, [5:4] energy, [7:6] health.
REQ-009 modo_sel  output  2  index of the need currently selected.
REQ-010 activo  output  4  one-hot-per-need decay enables to the need counters.
REQ-011 accion  output  4  one-cycle action pulse routed to one need counter.
REQ-012 estado  output  3  pet state code.
REQ-013 alarma  output  1  high while any need level is 0 and the pet is not dead.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer and rising-edge detector, giving a 1-cycle pulse 3 cycles after the edge.
REQ-015 FSM states SHALL be IDLE, SELECT, ACTION, SLEEP and DEAD.
REQ-016 In IDLE, activo=4'b1111 and accion=0; a btn_mode pulse SHALL move to SELECT, keep modo_sel and clear the select timer.
REQ-017 In SELECT, a btn_mode pulse SHALL increment modo_sel modulo 4 (3 wraps to 0) and clear the timer.
REQ-018 In SELECT, a btn_action pulse SHALL move to ACTION; if btn_mode and btn_action pulse in the same cycle, action wins and modo_sel is unchanged.
REQ-019 ACTION SHALL last exactly one cycle, assert accion[modo_sel]=1, and return to SELECT with the timer cleared; the pulse is issued even when the level is already 3.
REQ-020 In SELECT the timer SHALL count tick pulses and, on reaching TIEMPO_SEL, return to IDLE on that cycle.
REQ-021 In SELECT and ACTION, activo SHALL stay 4'b1111.
REQ-022 Health level 0 SHALL force DEAD from any state on the next edge, with priority over all other transitions.
REQ-023 In DEAD, activo=0, accion=0 and buttons are ignored; only reset exits DEAD.
REQ-024 alarma SHALL be registered: 1 when any 2-bit field of nivel is 0 and estado is not DEAD.
REQ-025 Outputs SHALL be registered, with a 1-cycle latency from the decision cycle.

Reset
REQ-026 Reset asserted mid-operation SHALL immediately set estado=IDLE, modo_sel=0, activo=4'b1111, accion=0, alarma=0, clear the timers and clear the synchronizer flops.

Configuration
REQ-027 Macro MODE_SCHEDULER_AUTO_SLEEP_EN, when defined, SHALL make IDLE move to SLEEP when the energy level is 0.
REQ-028 With the macro defined, SLEEP SHALL set activo=4'b1011 and pulse accion[2] on each tick.
REQ-029 With the macro defined, SLEEP SHALL exit to IDLE when energy reaches 3 or on a btn_action pulse; DEAD still has priority.
REQ-030 Without the macro, SLEEP SHALL be unreachable and no SLEEP logic is synthesized.

Structure
REQ-031 The state codes (IDLE=0, SELECT=1, ACTION=2, SLEEP=3, DEAD=4), the need indices (HAMBRE=0, DIVERSION=1, ENERGIA=2, SALUD=3) and the level constants (MAX=3, MIN=0) SHALL reside in shared package pet_pkg.
REQ-032 The synchronizer and edge detector SHALL be the sub-module btn_edge, instantiated twice.

Verification
REQ-033 Reset, then 5 btn_mode presses -> SELECT entered, then modo_sel=0,1,2,3,0 across the next presses (wrap).
REQ-034 modo_sel=2, btn_action -> accion=4'b0100 for exactly 1 cycle, estado returns to SELECT.
REQ-035 SELECT with no presses for 10 ticks -> IDLE on the 10th tick; simultaneous mode and action pulses -> action only, modo_sel unchanged.
REQ-036 nivel[7:6]=0 during SELECT -> DEAD next edge, activo=0, alarma=0, buttons ignored until B_reset.
REQ-037 With the macro defined, energy=0 in IDLE -> SLEEP, activo=4'b1011, accion[2] on each tick, exit when energy=3; without the macro, estado stays IDLE and alarma=1.
REQ-038 B_reset asserted during ACTION -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/pet_pkg.sv
// Shared constants for the pet mode scheduler: pet state codes, need
// indices into the packed level bus, and the level limits.
package pet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_ACTION = 3'd2,
        ST_SLEEP  = 3'd3,
        ST_DEAD   = 3'd4
    } pet_state_e;

    localparam int HAMBRE    = 0;
    localparam int DIVERSION = 1;
    localparam int ENERGIA   = 2;
    localparam int SALUD     = 3;

    localparam logic [1:0] NIVEL_MAX = 2'd3;
    localparam logic [1:0] NIVEL_MIN = 2'd0;

    // Extract the 2-bit level of need idx from the packed level bus.
    function automatic logic [1:0] need_level(input logic [7:0] nivel, input int idx);
        return nivel[2*idx +: 2];
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: two-flop synchronizer followed by a rising-edge
// detector with a registered one-cycle pulse output. A button edge
// shows up on pulse three clocks after it is first sampled.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic pulse_q, pulse_d;

    // Next-state of the synchronizer chain and the edge pulse.
    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        pulse_d = sync2_q & ~prev_q;
    end

    // Synchronizer, history and pulse flops; reset clears them all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/mode_scheduler.sv
// Pet mode scheduler: walks IDLE/SELECT/ACTION/DEAD from two buttons and
// the need levels, and drives decay enables and action pulses to the four
// need counters. All outputs are registered.
// Optional feature: define MODE_SCHEDULER_AUTO_SLEEP_EN to enable the
// SLEEP state (entered from IDLE when energy is empty).
module mode_scheduler
    import pet_pkg::*;
#(
    parameter int TIEMPO_SEL = 10,
    parameter int N_NEEDS    = 4
) (
    input  logic       clk,
    input  logic       B_reset,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_action,
    input  logic [7:0] nivel,
    output logic [1:0] modo_sel,
    output logic [3:0] activo,
    output logic [3:0] accion,
    output logic [2:0] estado,
    output logic       alarma
);

    localparam int         TW        = (TIEMPO_SEL > 1) ? $clog2(TIEMPO_SEL) : 1;
    localparam logic [3:0] ACT_ALL   = 4'((1 << N_NEEDS) - 1);
    localparam logic [1:0] MODO_LAST = 2'(N_NEEDS - 1);
`ifdef MODE_SCHEDULER_AUTO_SLEEP_EN
    localparam logic [3:0] ACT_SLEEP = ACT_ALL & ~(4'b0001 << ENERGIA);
`endif

    logic          mode_p;
    logic          action_p;
    logic          any_zero;
    pet_state_e    state_q, state_d;
    logic [1:0]    modo_sel_q, modo_sel_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    activo_q, activo_d;
    logic [3:0]    accion_q, accion_d;
    logic          alarma_q, alarma_d;

    btn_edge u_edge_mode (
        .clk    (clk),
        .rst_n  (B_reset),
        .btn_in (btn_mode),
        .pulse  (mode_p)
    );

    btn_edge u_edge_action (
        .clk    (clk),
        .rst_n  (B_reset),
        .btn_in (btn_action),
        .pulse  (action_p)
    );

    // State, selection and select-timer transitions; empty health wins over everything.
    always_comb begin
        state_d    = state_q;
        modo_sel_d = modo_sel_q;
        timer_d    = timer_q;
        if (need_level(nivel, SALUD) == NIVEL_MIN) begin
            state_d = ST_DEAD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timer_d = '0;
                    if (mode_p)
                        state_d = ST_SELECT;
`ifdef MODE_SCHEDULER_AUTO_SLEEP_EN
                    else if (need_level(nivel, ENERGIA) == NIVEL_MIN)
                        state_d = ST_SLEEP;
`endif
                end
                ST_SELECT: begin
                    if (action_p) begin
                        state_d = ST_ACTION;
                    end else if (mode_p) begin
                        modo_sel_d = (modo_sel_q == MODO_LAST) ? 2'd0 : modo_sel_q + 2'd1;
                        timer_d    = '0;
                    end else if (tick) begin
                        if (timer_q == TW'(TIEMPO_SEL - 1)) begin
                            state_d = ST_IDLE;
                            timer_d = '0;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                end
                ST_ACTION: begin
                    state_d = ST_SELECT;
                    timer_d = '0;
                end
`ifdef MODE_SCHEDULER_AUTO_SLEEP_EN
                ST_SLEEP: begin
                    if (action_p || need_level(nivel, ENERGIA) == NIVEL_MAX)
                        state_d = ST_IDLE;
                end
`endif
                ST_DEAD: state_d = ST_DEAD;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output values for the state being entered, so they line up with estado.
    always_comb begin
        activo_d = ACT_ALL;
        accion_d = '0;
        any_zero = 1'b0;
        for (int i = HAMBRE; i <= SALUD; i++) begin
            if (need_level(nivel, i) == NIVEL_MIN)
                any_zero = 1'b1;
        end
        alarma_d = any_zero && (state_d != ST_DEAD);
        case (state_d)
            ST_DEAD:   activo_d = '0;
            ST_ACTION: accion_d = 4'b0001 << modo_sel_d;
`ifdef MODE_SCHEDULER_AUTO_SLEEP_EN
            ST_SLEEP: begin
                activo_d          = ACT_SLEEP;
                accion_d[ENERGIA] = tick;
            end
`endif
            default: ;
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge B_reset) begin
        if (!B_reset) begin
            state_q    <= ST_IDLE;
            modo_sel_q <= 2'd0;
            timer_q    <= '0;
            activo_q   <= ACT_ALL;
            accion_q   <= '0;
            alarma_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            modo_sel_q <= modo_sel_d;
            timer_q    <= timer_d;
            activo_q   <= activo_d;
            accion_q   <= accion_d;
            alarma_q   <= alarma_d;
        end
    end

    assign estado   = state_q;
    assign modo_sel = modo_sel_q;
    assign activo   = activo_q;
    assign accion   = accion_q;
    assign alarma   = alarma_q;

endmodule

// File: tb/tb_mode_scheduler.sv
// Self-checking bench for mode_scheduler: directed table, hand-written
// corner sequences, then randomized stimulus against a behavioural model.
module tb_mode_scheduler;

    localparam int TIEMPO = 10;
    localparam int S_IDLE = 0, S_SELECT = 1, S_ACTION = 2, S_SLEEP = 3, S_DEAD = 4;

    logic       clk = 1'b0;
    logic       B_reset = 1'b0;
    logic       tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_action = 1'b0;
    logic [7:0] nivel = 8'hFF;
    logic [1:0] modo_sel;
    logic [3:0] activo;
    logic [3:0] accion;
    logic [2:0] estado;
    logic       alarma;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mode_scheduler #(.TIEMPO_SEL(TIEMPO), .N_NEEDS(4)) dut (
        .clk        (clk),
        .B_reset    (B_reset),
        .tick       (tick),
        .btn_mode   (btn_mode),
        .btn_action (btn_action),
        .nivel      (nivel),
        .modo_sel   (modo_sel),
        .activo     (activo),
        .accion     (accion),
        .estado     (estado),
        .alarma     (alarma)
    );

    // Compare all outputs against the required values.
    task automatic check(input string name, input int e_est, input int e_modo,
                         input int e_acc, input int e_act, input int e_alm);
        n_checks++;
        if ({estado, modo_sel, accion, activo, alarma} !==
            {3'(e_est), 2'(e_modo), 4'(e_acc), 4'(e_act), 1'(e_alm)}) begin
            n_fail++;
            $display("FAIL %s: got estado=%0d modo_sel=%0d accion=%b activo=%b alarma=%b ; required estado=%0d modo_sel=%0d accion=%b activo=%b alarma=%b",
                     name, estado, modo_sel, accion, activo, alarma,
                     e_est, e_modo, 4'(e_acc), 4'(e_act), e_alm);
        end else begin
            $display("ok   %s: estado=%0d modo_sel=%0d accion=%b activo=%b alarma=%b",
                     name, estado, modo_sel, accion, activo, alarma);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the buttons for one sampled edge, then idle until the FSM has acted.
    task automatic press(input bit m, input bit a);
        btn_mode   = m;
        btn_action = a;
        step();
        btn_mode   = 1'b0;
        btn_action = 1'b0;
        repeat (3) step();
    endtask

    // ---------------- behavioural reference model ----------------
    int m_st, m_modo, m_timer, m_acc, m_act, m_alm;
    bit hm[4];
    bit ha[4];

    function automatic void model_reset();
        m_st = S_IDLE; m_modo = 0; m_timer = 0;
        m_acc = 0; m_act = 15; m_alm = 0;
        for (int i = 0; i < 4; i++) begin
            hm[i] = 1'b0;
            ha[i] = 1'b0;
        end
    endfunction

    // One clock edge of the specified behaviour, given the inputs held over it.
    function automatic void model_step(input bit t, input bit bm, input bit ba, input logic [7:0] lv);
        int  lvl[4];
        bit  zero;
        bit  pm, pa;
        // A press is acted on when the button was seen high three edges ago after being low.
        pm = hm[2] && !hm[3];
        pa = ha[2] && !ha[3];
        zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lvl[i] = int'((lv >> (2 * i)) & 8'd3);
            if (lvl[i] == 0) zero = 1'b1;
        end
        if (lvl[3] == 0) begin
            m_st = S_DEAD;
        end else begin
            case (m_st)
                S_IDLE: begin
                    m_timer = 0;
                    if (pm) m_st = S_SELECT;
`ifdef MODE_SCHEDULER_AUTO_SLEEP_EN
                    else if (lvl[2] == 0) m_st = S_SLEEP;
`endif
                end
                S_SELECT: begin
                    if (pa) m_st = S_ACTION;
                    else if (pm) begin
                        m_modo  = (m_modo + 1) % 4;
                        m_timer = 0;
                    end else if (t) begin
                        m_timer++;
                        if (m_timer == TIEMPO) begin
                            m_st    = S_IDLE;
                            m_timer = 0;
                        end
                    end
                end
                S_ACTION: begin
                    m_st    = S_SELECT;
                    m_timer = 0;
                end
                S_SLEEP: if (pa || lvl[2] == 3) m_st = S_IDLE;
                default: ;
            endcase
        end
        m_act = (m_st == S_DEAD) ? 0 : (m_st == S_SLEEP) ? 11 : 15;
        m_acc = (m_st == S_ACTION) ? (1 << m_modo) : (m_st == S_SLEEP && t) ? 4 : 0;
        m_alm = (zero && m_st != S_DEAD) ? 1 : 0;
        for (int i = 3; i > 0; i--) begin
            hm[i] = hm[i-1];
            ha[i] = ha[i-1];
        end
        hm[0] = bm;
        ha[0] = ba;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        bit         m;
        bit         a;
        logic [7:0] lv;
        int         cyc;
        int         e_est, e_modo, e_acc, e_act, e_alm;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{1, 0, 8'hFF, 4, S_SELECT, 0, 0, 15, 0};
        vecs[1]  = '{1, 0, 8'hFF, 4, S_SELECT, 1, 0, 15, 0};
        vecs[2]  = '{1, 0, 8'hFF, 4, S_SELECT, 2, 0, 15, 0};
        vecs[3]  = '{1, 0, 8'hFF, 4, S_SELECT, 3, 0, 15, 0};
        vecs[4]  = '{1, 0, 8'hFF, 4, S_SELECT, 0, 0, 15, 0};
        vecs[5]  = '{1, 0, 8'hFF, 4, S_SELECT, 1, 0, 15, 0};
        vecs[6]  = '{1, 0, 8'hFF, 4, S_SELECT, 2, 0, 15, 0};
        vecs[7]  = '{0, 1, 8'hFF, 4, S_ACTION, 2, 4, 15, 0};
        vecs[8]  = '{0, 0, 8'hFF, 1, S_SELECT, 2, 0, 15, 0};
        vecs[9]  = '{1, 1, 8'hFF, 4, S_ACTION, 2, 4, 15, 0};
        vecs[10] = '{0, 0, 8'hFF, 1, S_SELECT, 2, 0, 15, 0};
        vecs[11] = '{0, 0, 8'hFC, 1, S_SELECT, 2, 0, 15, 1};
        vecs[12] = '{0, 0, 8'hFF, 1, S_SELECT, 2, 0, 15, 0};
        vecs[13] = '{1, 0, 8'hF3, 4, S_SELECT, 3, 0, 15, 1};
        vecs[14] = '{0, 0, 8'hFF, 1, S_SELECT, 3, 0, 15, 0};

        // Reset state
        B_reset = 1'b0;
        repeat (2) step();
        check("reset_state", S_IDLE, 0, 0, 15, 0);
        B_reset = 1'b1;
        step();
        check("idle_after_reset", S_IDLE, 0, 0, 15, 0);

        // Table: select wrap, action pulse, simultaneous press, alarm
        for (int i = 0; i < 15; i++) begin
            nivel      = vecs[i].lv;
            btn_mode   = vecs[i].m;
            btn_action = vecs[i].a;
            step();
            btn_mode   = 1'b0;
            btn_action = 1'b0;
            for (int c = 1; c < vecs[i].cyc; c++) step();
            check($sformatf("vec%0d", i), vecs[i].e_est, vecs[i].e_modo,
                  vecs[i].e_acc, vecs[i].e_act, vecs[i].e_alm);
        end

        // Select timeout: tenth tick returns to IDLE, selection kept
        for (int i = 1; i <= TIEMPO; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (i == TIEMPO - 1) check("timeout_tick9", S_SELECT, 3, 0, 15, 0);
            if (i == TIEMPO)     check("timeout_tick10", S_IDLE, 3, 0, 15, 0);
        end
        press(1'b1, 1'b0);
        check("reenter_select_keeps_modo", S_SELECT, 3, 0, 15, 0);

        // A mode press restarts the select timer
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1; step(); tick = 1'b0;
        end
        press(1'b1, 1'b0);
        for (int i = 1; i <= TIEMPO; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (i == TIEMPO - 1) check("timer_cleared_tick9", S_SELECT, 0, 0, 15, 0);
            if (i == TIEMPO)     check("timer_cleared_tick10", S_IDLE, 0, 0, 15, 0);
        end

        // Health empty in SELECT -> DEAD, buttons ignored until reset
        press(1'b1, 1'b0);
        check("select_before_dead", S_SELECT, 0, 0, 15, 0);
        nivel = 8'h3F;
        step();
        check("dead_entry", S_DEAD, 0, 0, 0, 0);
        press(1'b1, 1'b1);
        check("dead_ignores_buttons", S_DEAD, 0, 0, 0, 0);
        nivel = 8'hFF;
        tick  = 1'b1; step(); tick = 1'b0;
        press(1'b0, 1'b1);
        check("dead_sticky_after_heal", S_DEAD, 0, 0, 0, 0);
        B_reset = 1'b0;
        #2;
        check("reset_exits_dead", S_IDLE, 0, 0, 15, 0);
        step();
        B_reset = 1'b1;
        step();

        // Energy empty in IDLE
        nivel = 8'hCF;
        step();
`ifdef MODE_SCHEDULER_AUTO_SLEEP_EN
        check("sleep_entry", S_SLEEP, 0, 0, 11, 1);
        tick = 1'b1; step(); tick = 1'b0;
        check("sleep_tick_feeds_energy", S_SLEEP, 0, 4, 11, 1);
        step();
        check("sleep_no_tick", S_SLEEP, 0, 0, 11, 1);
        nivel = 8'hFF;
        step();
        check("sleep_exit_full", S_IDLE, 0, 0, 15, 0);
`else
        for (int i = 0; i < 4; i++) begin
            tick = 1'(i % 2); step(); tick = 1'b0;
        end
        check("no_sleep_stays_idle", S_IDLE, 0, 0, 15, 1);
        nivel = 8'hFF;
        step();
        check("no_sleep_alarm_clears", S_IDLE, 0, 0, 15, 0);
`endif

        // Reset asserted during ACTION
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("action_before_reset", S_ACTION, 0, 1, 15, 0);
        B_reset = 1'b0;
        #2;
        check("async_reset_in_action", S_IDLE, 0, 0, 15, 0);
        step();
        B_reset = 1'b1;

        // ---------------- randomized phase ----------------
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                B_reset = 1'b0;
                #2;
                model_reset();
                check($sformatf("rand%0d_reset", n), m_st, m_modo, m_acc, m_act, m_alm);
                step();
                B_reset = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) btn_mode   = ~btn_mode;
            if ($urandom_range(0, 5) == 0) btn_action = ~btn_action;
            tick = ($urandom_range(0, 2) == 0);
            for (int f = 0; f < 3; f++)
                nivel[2*f +: 2] = ($urandom_range(0, 15) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            nivel[7:6] = ($urandom_range(0, 199) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            step();
            model_step(tick, btn_mode, btn_action, nivel);
            check($sformatf("rand%0d", n), m_st, m_modo, m_acc, m_act, m_alm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
